// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencing controller.
// Synchronizes the board reset, then releases NUM_OUTS active-low domain
// resets in order, STAGE_DELAY cycles apart. A software reset request is
// serviced with a 4-phase REQ/ACK handshake.
module rst_seq_ctrl #(
  parameter int NUM_OUTS    = 3,
  parameter int STAGE_DELAY = 4,
  parameter int SW_HOLD     = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  output logic                SW_RST_ACK,
  output logic [NUM_OUTS-1:0] RST_OUT,
  output logic                ALL_RDY
);

  localparam int MAX_CNT = (STAGE_DELAY > SW_HOLD) ? STAGE_DELAY : SW_HOLD;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(SW_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_OUTS - 1);

  typedef enum logic [1:0] {
    ST_SEQ,
    ST_RUN,
    ST_SW_HOLD,
    ST_SW_WAIT
  } state_t;

  logic [1:0]          r_sync;
  logic                w_rst_n_int;

  state_t              r_state,   w_state;
  logic [CW-1:0]       r_cnt,     w_cnt;
  logic [IW-1:0]       r_idx,     w_idx;
  logic [NUM_OUTS-1:0] r_rst_out, w_rst_out;
  logic                r_ack,     w_ack;
  logic                r_rdy,     w_rdy;

  // Release synchronizer: asserts asynchronously, releases after two CLK edges.
  // NOTE: the synchronizer output is only ever used as an asynchronous reset,
  // so assertion still reaches every flop without waiting for a clock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_sync <= '0;
    else      r_sync <= {r_sync[0], 1'b1};
  end

  assign w_rst_n_int = r_sync[1];

  // State, counters and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge w_rst_n_int) begin
    if (!w_rst_n_int) begin
      r_state   <= ST_SEQ;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '0;
      r_ack     <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_rst_out <= w_rst_out;
      r_ack     <= w_ack;
      r_rdy     <= w_rdy;
    end
  end

  // Next-state and next-output logic.
  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_rst_out = r_rst_out;
    w_ack     = r_ack;
    w_rdy     = r_rdy;

    case (r_state)
      ST_SEQ: begin
        if (r_cnt == STAGE_LAST) begin
          // Bits release strictly in order, so shifting in a one releases bit idx.
          w_rst_out = (r_rst_out << 1) | NUM_OUTS'(1);
          w_cnt     = '0;
          if (r_idx == IDX_LAST) begin
            w_idx   = '0;
            w_rdy   = 1'b1;
            w_state = ST_RUN;
          end else begin
            w_idx   = r_idx + 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (SW_RST_REQ) begin
          w_rst_out = '0;
          w_rdy     = 1'b0;
          w_cnt     = '0;
          w_state   = ST_SW_HOLD;
        end
      end

      ST_SW_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_ack   = 1'b1;
          w_cnt   = '0;
          w_state = ST_SW_WAIT;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_SW_WAIT: begin
        if (!SW_RST_REQ) begin
          w_ack   = 1'b0;
          w_idx   = '0;
          w_cnt   = '0;
          w_state = ST_SEQ;
        end
      end

      default: w_state = ST_SEQ;
    endcase
  end

  assign RST_OUT    = r_rst_out;
  assign SW_RST_ACK = r_ack;
  assign ALL_RDY    = r_rdy;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: default instance (3/4/8) and a
// minimal instance (1/1/1), each compared against an event-timeline model.
module tb_rst_seq_ctrl;

  logic       CLK = 1'b0;
  logic       rst_a = 1'b1, req_a = 1'b0;
  logic       rst_b = 1'b1, req_b = 1'b0;
  logic [2:0] rst_out_a;
  logic [0:0] rst_out_b;
  logic       ack_a, rdy_a, ack_b, rdy_b;

  int n_checks = 0;
  int n_errors = 0;

  rst_seq_ctrl #(.NUM_OUTS(3), .STAGE_DELAY(4), .SW_HOLD(8)) u_dut_a (
    .CLK(CLK), .RST(rst_a), .SW_RST_REQ(req_a),
    .SW_RST_ACK(ack_a), .RST_OUT(rst_out_a), .ALL_RDY(rdy_a)
  );

  rst_seq_ctrl #(.NUM_OUTS(1), .STAGE_DELAY(1), .SW_HOLD(1)) u_dut_b (
    .CLK(CLK), .RST(rst_b), .SW_RST_REQ(req_b),
    .SW_RST_ACK(ack_b), .RST_OUT(rst_out_b), .ALL_RDY(rdy_b)
  );

  always #10 CLK = ~CLK;

  // Reference model: phase plus "edges elapsed in this phase".
  typedef enum {M_OFF, M_SEQ, M_RUN, M_HOLD, M_WAIT} mmode_t;
  typedef struct {
    mmode_t mode;
    int     t;
  } model_t;

  function automatic model_t m_step(model_t m, bit req, int n, int sd, int sh);
    model_t r = m;
    case (m.mode)
      M_OFF:  begin r.t = m.t + 1; if (r.t == 2) begin r.mode = M_SEQ; r.t = 0; end end
      M_SEQ:  begin r.t = m.t + 1; if (r.t / sd >= n) r.mode = M_RUN; end
      M_RUN:  if (req) begin r.mode = M_HOLD; r.t = 0; end
      M_HOLD: begin r.t = m.t + 1; if (r.t == sh) r.mode = M_WAIT; end
      M_WAIT: if (!req) begin r.mode = M_SEQ; r.t = 0; end
      default: r.mode = M_OFF;
    endcase
    return r;
  endfunction

  function automatic int m_rst_out(model_t m, int n, int sd);
    int k;
    if (m.mode == M_RUN) return (1 << n) - 1;
    if (m.mode != M_SEQ) return 0;
    k = m.t / sd;
    if (k > n) k = n;
    return (1 << k) - 1;
  endfunction

  model_t ma = '{M_OFF, 0};
  model_t mb = '{M_OFF, 0};

  always @(posedge CLK or negedge rst_a)
    if (!rst_a) ma <= '{M_OFF, 0};
    else        ma <= m_step(ma, req_a, 3, 4, 8);

  always @(posedge CLK or negedge rst_b)
    if (!rst_b) mb <= '{M_OFF, 0};
    else        mb <= m_step(mb, req_b, 1, 1, 1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge CLK) begin
    check("a_rst_out", 32'(rst_out_a), 32'(m_rst_out(ma, 3, 4)));
    check("a_ack",     32'(ack_a),     32'(ma.mode == M_WAIT));
    check("a_rdy",     32'(rdy_a),     32'(ma.mode == M_RUN));
    check("b_rst_out", 32'(rst_out_b), 32'(m_rst_out(mb, 1, 1)));
    check("b_ack",     32'(ack_b),     32'(mb.mode == M_WAIT));
    check("b_rdy",     32'(rdy_b),     32'(mb.mode == M_RUN));
  end

  task automatic next_cyc();
    @(negedge CLK);
    #2;
  endtask

  // Release RST_A between edges and check the default power-up schedule.
  task automatic pu_sched_a(input string tag);
    rst_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge CLK);
      #1;
      if (k == 5)  check({tag, "_e5"},  32'(rst_out_a), 32'h0);
      if (k == 6)  check({tag, "_e6"},  32'(rst_out_a), 32'h1);
      if (k == 10) check({tag, "_e10"}, 32'(rst_out_a), 32'h3);
      if (k == 13) check({tag, "_e13rdy"}, 32'(rdy_a), 32'h0);
      if (k == 14) begin
        check({tag, "_e14"},    32'(rst_out_a), 32'h7);
        check({tag, "_e14rdy"}, 32'(rdy_a),     32'h1);
      end
    end
  endtask

  task automatic rand_phase(input bit is_b, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      next_cyc();
      if ($urandom_range(0, 5) == 0) begin
        if (is_b) req_b = ~req_b; else req_a = ~req_a;
      end
      if ($urandom_range(0, 149) == 0) begin
        if (is_b) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        if (is_b) check("b_rand_async", 32'({rst_out_b, ack_b, rdy_b}), 32'h0);
        else      check("a_rand_async", 32'({rst_out_a, ack_a, rdy_a}), 32'h0);
        next_cyc();
        if (is_b) rst_b = 1'b1; else rst_a = 1'b1;
      end
    end
  endtask

  task automatic drive_a();
    #1 rst_a = 1'b0;
    check("a_reset_state", 32'({rst_out_a, ack_a, rdy_a}), 32'h0);
    next_cyc();
    next_cyc();
    pu_sched_a("pu");

    // Reset mid-sequence, 10 ns after E10.
    next_cyc();
    rst_a = 1'b0;
    next_cyc();
    rst_a = 1'b1;
    for (int k = 1; k <= 10; k++) @(posedge CLK);
    #1;
    check("mid_pre", 32'(rst_out_a), 32'h3);
    #9 rst_a = 1'b0;
    #1;
    check("mid_async_out", 32'(rst_out_a), 32'h0);
    check("mid_async_rdy", 32'(rdy_a),     32'h0);
    next_cyc();
    pu_sched_a("mid");

    // Software reset handshake.
    next_cyc();
    req_a = 1'b1;
    @(posedge CLK);
    #1;
    check("sw_er_out", 32'(rst_out_a), 32'h0);
    check("sw_er_rdy", 32'(rdy_a),     32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      check("sw_ack_timing", 32'(ack_a), (k == 8) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      check("sw_wait_ack", 32'(ack_a),     32'h1);
      check("sw_wait_out", 32'(rst_out_a), 32'h0);
    end
    next_cyc();
    req_a = 1'b0;
    @(posedge CLK);
    #1;
    check("sw_ea_ack", 32'(ack_a), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLK);
      #1;
      if (k == 3)  check("sw_ea3",  32'(rst_out_a), 32'h0);
      if (k == 4)  check("sw_ea4",  32'(rst_out_a), 32'h1);
      if (k == 8)  check("sw_ea8",  32'(rst_out_a), 32'h3);
      if (k == 12) check("sw_ea12", 32'(rst_out_a), 32'h7);
    end

    // Request raised during SEQ is deferred to the first RUN cycle.
    next_cyc();
    rst_a = 1'b0;
    next_cyc();
    rst_a = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(posedge CLK);
      #1;
      if (k == 2)  req_a = 1'b1;
      if (k == 14) check("seqreq_e14", 32'({rst_out_a, rdy_a}), 32'hF);
      if (k == 15) check("seqreq_e15", 32'({rst_out_a, rdy_a}), 32'h0);
      if (k == 22) check("seqreq_e22ack", 32'(ack_a), 32'h0);
      if (k == 23) check("seqreq_e23ack", 32'(ack_a), 32'h1);
    end

    // RST in SW_WAIT with ACK high, REQ kept high.
    next_cyc();
    rst_a = 1'b0;
    #1;
    check("wait_rst_ack", 32'(ack_a),     32'h0);
    check("wait_rst_out", 32'(rst_out_a), 32'h0);
    next_cyc();
    pu_sched_a("wait_rst");
    @(posedge CLK);
    #1;
    check("wait_rst_retake", 32'({rst_out_a, rdy_a}), 32'h0);

    rand_phase(1'b0, 2500);
  endtask

  task automatic drive_b();
    #1 rst_b = 1'b0;
    next_cyc();
    next_cyc();
    rst_b = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK);
      #1;
      if (k == 2) check("b_e2", 32'({rst_out_b, rdy_b}), 32'h0);
      if (k == 3) check("b_e3", 32'({rst_out_b, rdy_b}), 32'h3);
    end
    req_b = 1'b1;
    @(posedge CLK);
    #1;
    check("b_er",  32'({rst_out_b, ack_b, rdy_b}), 32'h0);
    @(posedge CLK);
    #1;
    check("b_ack", 32'(ack_b), 32'h1);
    rand_phase(1'b1, 2500);
  endtask

  initial begin
    fork
      drive_a();
      drive_b();
    join
    next_cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencing controller for multi-domain startup. It synchronizes the board-level asynchronous reset internally, then releases NUM_OUTS active-low domain resets in fixed order, STAGE_DELAY cycles apart. It also services a software reset request through a 4-phase REQ/ACK handshake. It sits at the top of the clocking/reset tree and drives the per-block reset inputs of the datapath.

## Interface
- NUM_OUTS, 3: number of sequenced domain reset outputs (≥1)
- STAGE_DELAY, 4: CLK cycles between consecutive releases (≥1)
- SW_HOLD, 8: CLK cycles all outputs are held asserted on a software reset before ACK (≥1)

- CLK  in  1  single system clock, rising-edge
- RST  in  1  asynchronous, active-low reset
- SW_RST_REQ  in  1  software reset request, level, synchronous to CLK
- SW_RST_ACK  out  1  software reset acknowledge
- RST_OUT  out  NUM_OUTS  active-low domain resets; bit 0 released first
- ALL_RDY  out  1  high when every RST_OUT bit is released

## Operation
- Internal 2-flop release synchronizer on RST:
  - Assertion is asynchronous.
  - Deassertion reaches the FSM on the 2nd rising CLK edge with RST high.
- RST low, at any time and in any state, takes effect immediately without waiting for CLK:
  - RST_OUT = all 0, SW_RST_ACK = 0, ALL_RDY = 0.
  - FSM = SEQ, stage index = 0, counter = 0.
- FSM states:
  - SEQ: counter increments each cycle. At counter = STAGE_DELAY−1, RST_OUT[idx] is set to 1, counter clears and idx increments. When idx = NUM_OUTS−1 is released, go to RUN.
  - RUN: all outputs released, ALL_RDY = 1. SW_RST_REQ sampled high → SW_HOLD.
  - SW_HOLD: on entry, RST_OUT = all 0 and ALL_RDY = 0. Counter counts SW_HOLD cycles, then SW_RST_ACK = 1 and go to SW_WAIT.
  - SW_WAIT: ACK held 1 while REQ stays high. REQ sampled low → ACK = 0, idx = 0, counter = 0, go to SEQ.
- SW_RST_REQ is ignored in SEQ, SW_HOLD and SW_WAIT:
  - A request held high through SEQ is taken on the first RUN cycle.
  - A request that drops before RUN is lost.
- RST_OUT bits only move low→high in SEQ, and only all-together high→low (RST or SW_HOLD entry). No bit ever releases out of order.
- Counter width: $clog2(max(STAGE_DELAY, SW_HOLD)+1). No wrap inside a phase.
- All outputs are registered; there is no combinational path from any input to any output.

## Timing
- E1 = first rising CLK edge with RST high; internal release occurs at E2.
- RST_OUT[i] rises at edge E2 + (i+1)·STAGE_DELAY.
- ALL_RDY rises on the same edge as RST_OUT[NUM_OUTS−1].
- Defaults: bit0 at E6, bit1 at E10, bit2 + ALL_RDY at E14.
- REQ first sampled high in RUN at edge Er:
  - RST_OUT = 0 and ALL_RDY = 0 after Er.
  - SW_RST_ACK = 1 after Er + SW_HOLD.
- REQ first sampled low in SW_WAIT at edge Ea:
  - ACK = 0 after Ea.
  - RST_OUT[i] rises at Ea + (i+1)·STAGE_DELAY; there is no resynchronization delay on the software path.
- RST asserted mid-sequence or mid-handshake: outputs clear within the same cycle, asynchronously. Release timing then restarts from E1 of the next RST deassertion.

## Test plan
- Power-up, defaults: RST low 2 cycles, then high between edges → RST_OUT 000 until E6, 001 at E6, 011 at E10, 111 + ALL_RDY=1 at E14.
- Reset mid-sequence: assert RST 10 ns after E10 (RST_OUT=011) → RST_OUT=000 and ALL_RDY=0 before the next edge. Release again → same E6/E10/E14 schedule.
- Software reset: in RUN, REQ=1 at Er → RST_OUT=000 after Er, ACK=1 after Er+8. Keep REQ high 5 more cycles → ACK stays 1, RST_OUT stays 000. Drop REQ → ACK=0 at Ea; RST_OUT 001/011/111 at Ea+4/+8/+12.
- REQ during SEQ: REQ=1 from E3 onward → no effect until E14. Hold entered at E15: RST_OUT=000 after E15, ACK at E23.
- RST asserted in SW_WAIT with ACK=1 → ACK=0 and RST_OUT=000 asynchronously. After release, the normal power-up schedule is followed even though REQ is still high; the request is taken again on the first RUN cycle.
- Parameter sweep NUM_OUTS=1, STAGE_DELAY=1, SW_HOLD=1 → RST_OUT[0] and ALL_RDY rise at E3. SW ACK occurs 1 cycle after Er.
